// File: rtl/clk_stall_ctrl_if.sv
// Handshake/status bundle between the processor clock sequencer and its surroundings.
// The sequencer takes the slave side; whatever drives lock, stalls and divide requests takes the master side.
interface clk_stall_ctrl_if #(
    parameter int NUM_STALL = 2,
    parameter int DIV_W     = 4
) ();
    logic                 pll_locked;
    logic [NUM_STALL-1:0] stall_req;
    logic [DIV_W-1:0]     div_sel;
    logic                 div_load;
    logic                 proc_ce;
    logic                 proc_rst_n;
    logic                 stall_active;
    logic [NUM_STALL-1:0] stall_src;
    logic                 timeout;
    logic [15:0]          stall_cycles;

    modport master (
        output pll_locked, stall_req, div_sel, div_load,
        input  proc_ce, proc_rst_n, stall_active, stall_src, timeout, stall_cycles
    );

    modport slave (
        input  pll_locked, stall_req, div_sel, div_load,
        output proc_ce, proc_rst_n, stall_active, stall_src, timeout, stall_cycles
    );
endinterface

// File: rtl/clk_stall_ctrl.sv
// Processor clock-enable and reset sequencer: lock bring-up, step-rate divider, stall merge, watchdog and stats.
// proc_ce is zero-latency on stall_req (combinational); all other outputs are registered one cycle.
// Stalls are always honoured; a stall on a step boundary holds the divider at that boundary until release.
module clk_stall_ctrl #(
    parameter int NUM_STALL = 2,
    parameter int DIV_W     = 4,
    parameter int LOCK_WAIT = 16,
    parameter int MAX_STALL = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    clk_stall_ctrl_if.slave    bus
);
    localparam int              LW_W        = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [LW_W-1:0] LOCK_LAST   = LW_W'(LOCK_WAIT - 1);
    localparam logic [15:0]     STALL_LIMIT = 16'(MAX_STALL);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SETTLE    = 2'd1,
        S_RUN       = 2'd2,
        S_STALL     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, lock_s_q;
    logic [LW_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0]     div_cur_q, div_cur_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]     div_pend_q, div_pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [15:0]          consec_q, consec_d;
    logic [15:0]          stall_cycles_q, stall_cycles_d;
    logic                 timeout_q, timeout_d;
    logic                 stall_active_q, stall_active_d;
    logic [NUM_STALL-1:0] stall_src_q, stall_src_d;
    logic                 proc_rst_n_q, proc_rst_n_d;

    logic any_stall, running, step_hit, proc_ce;

    assign any_stall = |bus.stall_req;
    assign running   = (state_q == S_RUN) || (state_q == S_STALL);
    assign step_hit  = (div_cnt_q == div_cur_q);
    // The first RUN cycle still has the processor in reset, so no step is offered there.
    assign proc_ce   = running & step_hit & ~any_stall & proc_rst_n_q;

    always_comb begin
        state_d        = state_q;
        lock_cnt_d     = lock_cnt_q;
        div_cur_d      = div_cur_q;
        div_cnt_d      = div_cnt_q;
        div_pend_d     = div_pend_q;
        pend_vld_d     = pend_vld_q;
        consec_d       = consec_q;
        stall_cycles_d = stall_cycles_q;
        timeout_d      = timeout_q;
        stall_active_d = running & any_stall;
        stall_src_d    = bus.stall_req;
        proc_rst_n_d   = running;

        case (state_q)
            S_WAIT_LOCK: if (lock_s_q) begin
                state_d    = S_SETTLE;
                lock_cnt_d = '0;
            end
            S_SETTLE: begin
                if (lock_cnt_q == LOCK_LAST) state_d = S_RUN;
                else                         lock_cnt_d = lock_cnt_q + LW_W'(1);
            end
            S_RUN:   if (any_stall)  state_d = S_STALL;
            S_STALL: if (!any_stall) state_d = S_RUN;
            default: state_d = S_WAIT_LOCK;
        endcase

        if (running && !any_stall) begin
            if (step_hit) begin
                div_cnt_d = '0;
                if (proc_ce && pend_vld_q) begin
                    div_cur_d  = div_pend_q;
                    pend_vld_d = 1'b0;
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        if (bus.div_load) begin
            if (!running) begin
                div_cur_d  = bus.div_sel;
                div_cnt_d  = '0;
                pend_vld_d = 1'b0;
            end else begin
                div_pend_d = bus.div_sel;
                pend_vld_d = 1'b1;
            end
        end

        if (running && any_stall && stall_cycles_q != 16'hFFFF)
            stall_cycles_d = stall_cycles_q + 16'd1;

        if (!any_stall)                             consec_d = '0;
        else if (running && consec_q != 16'hFFFF)   consec_d = consec_q + 16'd1;

        if (MAX_STALL != 0 && consec_d == STALL_LIMIT)
            timeout_d = 1'b1;

        // Lock loss wins over everything else this cycle; divide settings survive it.
        if (state_q != S_WAIT_LOCK && !lock_s_q) begin
            state_d    = S_WAIT_LOCK;
            lock_cnt_d = '0;
            div_cnt_d  = '0;
            div_cur_d  = div_cur_q;
            div_pend_d = div_pend_q;
            pend_vld_d = pend_vld_q;
            consec_d   = '0;
            timeout_d  = timeout_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_WAIT_LOCK;
            sync1_q        <= 1'b0;
            lock_s_q       <= 1'b0;
            lock_cnt_q     <= '0;
            div_cur_q      <= '0;
            div_cnt_q      <= '0;
            div_pend_q     <= '0;
            pend_vld_q     <= 1'b0;
            consec_q       <= '0;
            stall_cycles_q <= '0;
            timeout_q      <= 1'b0;
            stall_active_q <= 1'b0;
            stall_src_q    <= '0;
            proc_rst_n_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= bus.pll_locked;
            lock_s_q       <= sync1_q;
            lock_cnt_q     <= lock_cnt_d;
            div_cur_q      <= div_cur_d;
            div_cnt_q      <= div_cnt_d;
            div_pend_q     <= div_pend_d;
            pend_vld_q     <= pend_vld_d;
            consec_q       <= consec_d;
            stall_cycles_q <= stall_cycles_d;
            timeout_q      <= timeout_d;
            stall_active_q <= stall_active_d;
            stall_src_q    <= stall_src_d;
            proc_rst_n_q   <= proc_rst_n_d;
        end
    end

    assign bus.proc_ce      = proc_ce;
    assign bus.proc_rst_n   = proc_rst_n_q;
    assign bus.stall_active = stall_active_q;
    assign bus.stall_src    = stall_src_q;
    assign bus.timeout      = timeout_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_clk_stall_ctrl.sv
// Directed bring-up/divider/stall/watchdog/lock-loss steps plus a randomized stretch, checked against a
// phase-level reference model; a second instance with the watchdog disabled runs on the same stimulus.
module tb_clk_stall_ctrl;
    localparam int LW   = 16;
    localparam int MAXS = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_stall_ctrl_if #(.NUM_STALL(2), .DIV_W(4)) ifm ();
    clk_stall_ctrl_if #(.NUM_STALL(2), .DIV_W(4)) if0 ();

    clk_stall_ctrl #(.NUM_STALL(2), .DIV_W(4), .LOCK_WAIT(LW), .MAX_STALL(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifm));
    clk_stall_ctrl #(.NUM_STALL(2), .DIV_W(4), .LOCK_WAIT(LW), .MAX_STALL(0)) dut_nowd (
        .clk(clk), .rst_n(rst_n), .bus(if0));

    int checks = 0;
    int failures = 0;
    int n_cyc = 0;

    // driven inputs
    bit       pl_v;
    bit [1:0] sr_v;
    int       ds_v;
    bit       dl_v;

    // reference model: phase 0 = waiting for lock, 1 = settling, 2 = processor running (stalled or not)
    int m_phase, m_settle, m_cur, m_cnt, m_pend, m_consec, m_total;
    bit m_pvld, m_released, m_to, m_sa, m_s1, m_s2;
    bit [1:0] m_src;

    // last observed values from the main instance
    bit obs_ce, obs_rst, obs_to, obs_sa;
    int obs_sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ce();
        return (m_phase == 2) && m_released && (m_cnt == m_cur) && (sr_v == 2'b00);
    endfunction

    task automatic m_reset();
        m_phase = 0; m_settle = 0; m_cur = 0; m_cnt = 0; m_pend = 0; m_consec = 0; m_total = 0;
        m_pvld = 0; m_released = 0; m_to = 0; m_sa = 0; m_s1 = 0; m_s2 = 0; m_src = 2'b00;
    endtask

    task automatic m_edge();
        int  ph     = m_phase;
        bit  lock_s = m_s2;
        bit  any    = (sr_v != 2'b00);
        bit  run    = (ph == 2);
        bit  ce     = exp_ce();
        m_released = run;
        m_sa       = run && any;
        m_src      = sr_v;
        if (run && any && m_total < 65535) m_total++;
        m_s2 = m_s1;
        m_s1 = pl_v;
        if (ph != 0 && !lock_s) begin
            m_phase = 0; m_settle = 0; m_cnt = 0; m_consec = 0;
        end else begin
            if (!any) m_consec = 0;
            else if (run && m_consec < 65535) m_consec++;
            if (MAXS != 0 && m_consec == MAXS) m_to = 1;
            if (ph == 0 && lock_s) begin
                m_phase = 1; m_settle = 0;
            end else if (ph == 1) begin
                if (m_settle == LW - 1) m_phase = 2;
                else m_settle++;
            end
            if (run && !any) begin
                if (m_cnt == m_cur) begin
                    m_cnt = 0;
                    if (ce && m_pvld) begin m_cur = m_pend; m_pvld = 0; end
                end else m_cnt++;
            end
            if (dl_v) begin
                if (!run) begin m_cur = ds_v; m_cnt = 0; m_pvld = 0; end
                else begin m_pend = ds_v; m_pvld = 1; end
            end
        end
    endtask

    task automatic drive();
        ifm.pll_locked = pl_v; if0.pll_locked = pl_v;
        ifm.stall_req  = sr_v; if0.stall_req  = sr_v;
        ifm.div_sel    = 4'(ds_v); if0.div_sel = 4'(ds_v);
        ifm.div_load   = dl_v; if0.div_load   = dl_v;
    endtask

    task automatic check_all();
        chk("proc_ce", 32'(ifm.proc_ce), 32'(exp_ce()));
        chk("proc_rst_n", 32'(ifm.proc_rst_n), 32'(m_released));
        chk("stall_active", 32'(ifm.stall_active), 32'(m_sa));
        chk("stall_src", 32'(ifm.stall_src), 32'(m_src));
        chk("timeout", 32'(ifm.timeout), 32'(m_to));
        chk("stall_cycles", 32'(ifm.stall_cycles), 32'(m_total));
        chk("nowd_proc_ce", 32'(if0.proc_ce), 32'(exp_ce()));
        chk("nowd_timeout", 32'(if0.timeout), 32'd0);
        chk("nowd_stall_cycles", 32'(if0.stall_cycles), 32'(m_total));
        obs_ce = ifm.proc_ce; obs_rst = ifm.proc_rst_n; obs_to = ifm.timeout;
        obs_sa = ifm.stall_active; obs_sc = int'(ifm.stall_cycles);
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model on the rising edge.
    task automatic cyc(input bit pl, input bit [1:0] sr, input int ds, input bit dl);
        pl_v = pl; sr_v = sr; ds_v = ds; dl_v = dl;
        drive();
        #1;
        check_all();
        n_cyc++;
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    initial begin
        int lock_idx, lat, cnt;
        rst_n = 1'b0;
        pl_v = 0; sr_v = 2'b00; ds_v = 0; dl_v = 0;
        drive();
        m_reset();
        #2;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // lock bring-up
        for (int i = 0; i < 10; i++) cyc(1'b0, 2'b00, 0, 1'b0);
        lock_idx = n_cyc; lat = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 2'b00, 0, 1'b0);
            if (lat < 0 && obs_rst) lat = n_cyc - 1 - lock_idx - 1;
        end
        chk("lock_release_latency", 32'(lat), 32'd19);

        // divide by 4, then back to every cycle
        cyc(1'b1, 2'b00, 3, 1'b1);
        cyc(1'b1, 2'b00, 0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin cyc(1'b1, 2'b00, 0, 1'b0); cnt += int'(obs_ce); end
        chk("div4_step_count", 32'(cnt), 32'd3);
        cyc(1'b1, 2'b00, 0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'b00, 0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin cyc(1'b1, 2'b00, 0, 1'b0); cnt += int'(obs_ce); end
        chk("div1_step_count", 32'(cnt), 32'd6);

        // stall merge across two sources
        cnt = 0;
        for (int i = 0; i < 3; i++) begin cyc(1'b1, 2'b10, 0, 1'b0); cnt += int'(!obs_ce); end
        for (int i = 0; i < 2; i++) begin cyc(1'b1, 2'b01, 0, 1'b0); cnt += int'(!obs_ce); end
        chk("merge_ce_low_cycles", 32'(cnt), 32'd5);
        cyc(1'b1, 2'b00, 0, 1'b0);
        chk("merge_stall_cycles", 32'(obs_sc), 32'd5);
        chk("merge_release_step", 32'(obs_ce), 32'd1);

        // stall landing on a step boundary at divide-by-3
        cyc(1'b1, 2'b00, 2, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'b00, 0, 1'b0);
        for (int i = 0; i < 8 && !(m_cnt == m_cur); i++) cyc(1'b1, 2'b00, 0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin cyc(1'b1, 2'b01, 0, 1'b0); cnt += int'(obs_ce); end
        chk("boundary_stall_steps", 32'(cnt), 32'd0);
        cyc(1'b1, 2'b00, 0, 1'b0);
        chk("boundary_step_on_release", 32'(obs_ce), 32'd1);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin cyc(1'b1, 2'b00, 0, 1'b0); cnt += int'(obs_ce); end
        chk("boundary_followup_steps", 32'(cnt), 32'd3);

        // watchdog
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 2'b01, 0, 1'b0);
            if (i == 8) chk("timeout_before_limit", 32'(obs_to), 32'd0);
            if (i == 9) chk("timeout_at_limit", 32'(obs_to), 32'd1);
        end
        cyc(1'b1, 2'b00, 0, 1'b0);
        cyc(1'b1, 2'b00, 0, 1'b0);
        chk("timeout_sticky", 32'(obs_to), 32'd1);

        // lock loss during a stall
        cyc(1'b1, 2'b01, 0, 1'b0);
        lock_idx = n_cyc; lat = -1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 2'b01, 0, 1'b0);
            if (lat < 0 && !obs_rst) lat = n_cyc - 1 - lock_idx - 1;
        end
        chk("lockloss_reset_within_3", 32'(lat >= 0 && lat <= 3), 32'd1);
        for (int i = 0; i < 25; i++) cyc(1'b1, 2'b00, 0, 1'b0);
        chk("relock_released", 32'(obs_rst), 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [1:0] sr;
            sr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc(($urandom_range(0, 199) != 0), sr, int'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0));
        end

        // asynchronous reset in the middle of settling
        for (int i = 0; i < 25; i++) cyc(1'b1, 2'b00, 0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 2'b10, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("arst_stall_cycles", 32'(obs_sc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // long stall: counter saturation, watchdog-disabled instance stays clear
        for (int i = 0; i < 24; i++) cyc(1'b1, 2'b00, 0, 1'b0);
        for (int i = 0; i < 65540; i++) cyc(1'b1, 2'b01, 0, 1'b0);
        cyc(1'b1, 2'b00, 0, 1'b0);
        chk("sat_stall_cycles", 32'(obs_sc), 32'd65535);
        chk("sat_nowd_timeout", 32'(if0.timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
